// File: rtl/mpx_pkg.sv
// mpx_pkg: shared types and defaults for the stereo MPX receive path
package mpx_pkg;

    typedef enum logic {WAIT_FIRST, WAIT_SECOND} mpx_state_t;

    typedef logic signed [15:0] mpx_sample_t;

    localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/mpx_gap_timer.sv
// mpx_gap_timer: saturating count of idle cycles since the last clear
module mpx_gap_timer
    import mpx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic timeout_hit_o
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count_q, count_d;

    // Clear wins; otherwise count up and park at the limit
    always_comb count_d = clear_i ? '0 : (count_q == LIMIT) ? count_q : count_q + 1'b1;

    // Idle counter register
    always_ff @(posedge clk) count_q <= reset ? '0 : count_d;

    assign timeout_hit_o = (count_q == LIMIT);

endmodule

// File: rtl/stereo_mpx_demux.sv
// stereo_mpx_demux: pilot removal and R/L pair reassembly of an MPX sample stream
module stereo_mpx_demux
    import mpx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          mpx_in,
    input  logic                 mpx_valid,
    input  logic [15:0]          pilot_ref,
    input  logic                 swap,
    input  logic                 resync,
    output logic [15:0]          out_l,
    output logic [15:0]          out_r,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] pair_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    mpx_state_t           state_q;
    mpx_sample_t          sample, first_q, out_l_q, out_r_q;
    logic                 pair_swap_q, out_valid_q, timeout_hit;
    logic [CNT_WIDTH-1:0] pair_q, pair_d, drop_q, drop_d;

    mpx_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (mpx_valid | resync),
        .timeout_hit_o(timeout_hit)
    );

    // Pilot removal is a plain wrap subtraction, undoing the encoder's wrap add
    always_comb begin
        sample = mpx_sample_t'(mpx_in - pilot_ref);
        pair_d = &pair_q ? pair_q : pair_q + 1'b1;
        drop_d = &drop_q ? drop_q : drop_q + 1'b1;
    end

    // Pairing FSM with registered outputs; resync beats valid, valid beats timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_FIRST;
            first_q     <= '0;
            pair_swap_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            pair_q      <= '0;
            drop_q      <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (mpx_valid && (state_q == WAIT_FIRST || resync)) begin
                first_q     <= sample;
                pair_swap_q <= swap;
            end
            case (state_q)
                WAIT_FIRST: if (mpx_valid) state_q <= WAIT_SECOND;
                WAIT_SECOND: begin
                    if (resync) begin
                        drop_q  <= drop_d;
                        state_q <= mpx_valid ? WAIT_SECOND : WAIT_FIRST;
                    end else if (mpx_valid) begin
                        out_l_q     <= pair_swap_q ? first_q : sample;
                        out_r_q     <= pair_swap_q ? sample : first_q;
                        out_valid_q <= 1'b1;
                        pair_q      <= pair_d;
                        state_q     <= WAIT_FIRST;
                    end else if (timeout_hit) begin
                        drop_q  <= drop_d;
                        state_q <= WAIT_FIRST;
                    end
                end
                default: state_q <= WAIT_FIRST;
            endcase
        end
    end

    assign out_l      = out_l_q;
    assign out_r      = out_r_q;
    assign out_valid  = out_valid_q;
    assign pair_count = pair_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_stereo_mpx_demux.sv
// tb_stereo_mpx_demux: encoder-loopback scoreboard bench for stereo_mpx_demux
module tb_stereo_mpx_demux;

    localparam int TO = 64;

    logic        clk = 1'b0, reset = 1'b1;
    logic [15:0] mpx_in = '0, pilot_ref = '0;
    logic        mpx_valid = 1'b0, swap = 1'b0, resync = 1'b0;
    logic [15:0] out_l, out_r, sat_l, sat_r;
    logic        out_valid, sat_valid;
    logic [31:0] pair_count, drop_count;
    logic [1:0]  sat_pairs, sat_drops;
    int          checks = 0, errors = 0, exp_pairs = 0, exp_drops = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    stereo_mpx_demux #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .mpx_in(mpx_in), .mpx_valid(mpx_valid),
        .pilot_ref(pilot_ref), .swap(swap), .resync(resync),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid),
        .pair_count(pair_count), .drop_count(drop_count)
    );

    stereo_mpx_demux #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset(reset), .mpx_in(mpx_in), .mpx_valid(mpx_valid),
        .pilot_ref(pilot_ref), .swap(swap), .resync(resync),
        .out_l(sat_l), .out_r(sat_r), .out_valid(sat_valid),
        .pair_count(sat_pairs), .drop_count(sat_drops)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Encoder side: audio sample plus pilot, wrapped to 16 bits
    task automatic send(input logic [15:0] s, input logic [15:0] p, input logic sw, input logic rs);
        mpx_in    = s + p;
        pilot_ref = p;
        swap      = sw;
        resync    = rs;
        mpx_valid = 1'b1;
        step();
        mpx_valid = 1'b0;
        resync    = 1'b0;
    endtask

    // One stereo frame: R first unless swap, swap may change for the second sample
    task automatic send_pair(input logic [15:0] l, input logic [15:0] r, input logic sw, input logic sw2,
                             input logic [15:0] p1, input logic [15:0] p2);
        send(sw ? l : r, p1, sw, 1'b0);
        send(sw ? r : l, p2, sw2, 1'b0);
        exp_q.push_back({l, r});
        exp_pairs++;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pairs"}, pair_count, exp_pairs);
        check({tag, "_drops"}, drop_count, exp_drops);
        check({tag, "_sat_pairs"}, 32'(sat_pairs), exp_pairs > 3 ? 3 : exp_pairs);
        check({tag, "_sat_drops"}, 32'(sat_drops), exp_drops > 3 ? 3 : exp_drops);
    endtask

    // Every emitted pair must match the next frame the encoder sent
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("pair", {out_l, out_r}, mon_e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] p;
        p = 16'($urandom);
        idle(3);
        check("rst_l", out_l, 0);
        check("rst_r", out_r, 0);
        check("rst_valid", out_valid, 0);
        check_counts("rst");
        reset = 1'b0;
        step();

        send_pair(16'h2000, 16'h1000, 1'b0, 1'b0, 16'h0010, 16'h0010);
        check("basic_valid", out_valid, 1);
        check("basic_r", out_r, 16'h1000);
        check("basic_l", out_l, 16'h2000);
        check_counts("basic");
        step();
        check("valid_one_cycle", out_valid, 0);
        check("hold_l", out_l, 16'h2000);

        send_pair(16'hFFF5, 16'hFFF5, 1'b0, 1'b0, 16'h0010, 16'h0010);
        check("wrap_mpx", mpx_in, 16'h0005);
        check("wrap_l", out_l, 16'hFFF5);
        check("wrap_r", out_r, 16'hFFF5);

        send(16'h0999, p, 1'b0, 1'b0);
        idle(TO - 1);
        check("pre_timeout_drops", drop_count, exp_drops);
        idle(3);
        exp_drops++;
        check("timeout_drops", drop_count, exp_drops);
        send_pair(16'h0444, 16'h0333, 1'b0, 1'b0, p, p);
        check("after_timeout_r", out_r, 16'h0333);
        check("after_timeout_l", out_l, 16'h0444);

        send(16'h0555, p, 1'b0, 1'b0);
        idle(TO - 1);
        send(16'h0666, p, 1'b0, 1'b0);
        exp_q.push_back({16'h0666, 16'h0555});
        exp_pairs++;
        check_counts("gap_limit");

        send(16'h0100, 16'h0000, 1'b0, 1'b0);
        send(16'h0AAA, p, 1'b0, 1'b1);
        exp_drops++;
        check("resync_drops", drop_count, exp_drops);
        send(16'h0BBB, p, 1'b0, 1'b0);
        exp_q.push_back({16'h0BBB, 16'h0AAA});
        exp_pairs++;
        check("resync_r", out_r, 16'h0AAA);
        check("resync_l", out_l, 16'h0BBB);

        resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_idle_drops", drop_count, exp_drops);
        send(16'h0777, p, 1'b0, 1'b0);
        resync = 1'b1;
        step();
        resync = 1'b0;
        exp_drops++;
        check("resync_mid_drops", drop_count, exp_drops);

        send_pair(16'h0111, 16'h0222, 1'b1, 1'b0, p, 16'($urandom));
        check("swap_l", out_l, 16'h0111);
        check("swap_r", out_r, 16'h0222);

        send(16'h0888, p, 1'b1, 1'b0);
        idle(TO + 2);
        exp_drops++;
        check_counts("second_timeout");

        for (int i = 0; i < 500; i++)
            send_pair(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                      16'($urandom), 16'($urandom));
        check_counts("stream");

        send(16'($urandom), p, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check("midrst_l", out_l, 0);
        check("midrst_r", out_r, 0);
        check("midrst_valid", out_valid, 0);
        exp_pairs = 0;
        exp_drops = 0;
        check_counts("midrst");
        reset = 1'b0;
        send_pair(16'h1234, 16'h5678, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
        check("post_rst_r", out_r, 16'h5678);
        check("post_rst_l", out_l, 16'h1234);
        check_counts("post_rst");

        idle(2);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
